// File: rtl/chimpo_pkg.sv
// Shared definitions for the CHINPO interrupt controller: core state codes,
// datapath width and the request/service FSM encoding.
package chimpo_pkg;

    localparam int unsigned CHIMPO_DATA_W = 16;
    localparam int unsigned CORE_STATE_W  = 4;

    localparam logic [CORE_STATE_W-1:0] CORE_FETCH       = 4'd0;
    localparam logic [CORE_STATE_W-1:0] CORE_DECODE      = 4'd1;
    localparam logic [CORE_STATE_W-1:0] CORE_RESET_STATE = 4'd13;
    localparam logic [CORE_STATE_W-1:0] CORE_INTERRUPT   = 4'd14;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/chimpo_irq_sync.sv
// One interrupt line: two-flop synchroniser, history flop and rising-edge pulse.
module chimpo_irq_sync (
    input  logic CLK,
    input  logic Reset,
    input  logic irq_i,
    output logic rise_c_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= irq_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_c_o = s2_q & ~s3_q;

endmodule

// File: rtl/chimpo_interrupt_controller.sv
// Interrupt controller for the CHINPO core: pending/mask bookkeeping, fixed
// lowest-index priority and a committed request/ack/return handshake.
module chimpo_interrupt_controller
    import chimpo_pkg::*;
#(
    parameter int unsigned            NUM_IRQ    = 4,
    parameter int unsigned            DATA_W     = CHIMPO_DATA_W,
    parameter logic [DATA_W-1:0]      VEC_BASE   = 16'h0100,
    parameter logic [DATA_W-1:0]      VEC_STRIDE = 16'h0010,
    parameter logic [CORE_STATE_W-1:0] INT_STATE = CORE_INTERRUPT,
    localparam int unsigned           ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [NUM_IRQ-1:0]      IrqIn,
    input  logic [CORE_STATE_W-1:0] CurState,
    input  logic                    MaskWe,
    input  logic [NUM_IRQ-1:0]      MaskWdata,
    input  logic                    IntRet,
    output logic                    Int,
    output logic [DATA_W-1:0]       IntVector,
    output logic [ID_W-1:0]         IntId,
    output logic [NUM_IRQ-1:0]      Pending,
    output logic [NUM_IRQ-1:0]      Mask,
    output logic                    InService
);

    irq_state_e          state_q, state_d;
    logic                int_q, int_d;
    logic [DATA_W-1:0]   vec_q, vec_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [NUM_IRQ-1:0]  pending_q, pending_d;
    logic [NUM_IRQ-1:0]  mask_q, mask_d;
    logic                in_service_q, in_service_d;

    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  cand;
    logic [NUM_IRQ-1:0]  pending_clr;
    logic [ID_W-1:0]     win;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        chimpo_irq_sync u_sync (
            .CLK      (CLK),
            .Reset    (Reset),
            .irq_i    (IrqIn[g]),
            .rise_c_o (rise[g])
        );
    end

    assign cand = pending_q & mask_q;

    // Lowest index wins: scan from the top so the last hit is the smallest.
    always_comb begin
        win = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win = ID_W'(i);
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= IRQ_IDLE;
            int_q        <= 1'b0;
            vec_q        <= '0;
            id_q         <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            int_q        <= int_d;
            vec_q        <= vec_d;
            id_q         <= id_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        int_d        = int_q;
        vec_d        = vec_q;
        id_d         = id_q;
        in_service_d = in_service_q;
        pending_clr  = '0;
        mask_d       = MaskWe ? MaskWdata : mask_q;

        case (state_q)
            IRQ_IDLE: begin
                int_d        = 1'b0;
                in_service_d = 1'b0;
                if (|cand) begin
                    id_d    = win;
                    vec_d   = VEC_BASE + DATA_W'(win) * VEC_STRIDE;
                    int_d   = 1'b1;
                    state_d = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                // Request is committed; only the core's ack moves us on.
                if (CurState == INT_STATE) begin
                    pending_clr  = NUM_IRQ'(1) << id_q;
                    int_d        = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = IRQ_SERVICE;
                end
            end
            IRQ_SERVICE: begin
                int_d = 1'b0;
                if (IntRet) begin
                    in_service_d = 1'b0;
                    state_d      = IRQ_IDLE;
                end
            end
            default: begin
                int_d        = 1'b0;
                in_service_d = 1'b0;
                state_d      = IRQ_IDLE;
            end
        endcase

        // A fresh edge on the bit being acknowledged survives the clear.
        pending_d = (pending_q & ~pending_clr) | rise;
    end

    assign Int       = int_q;
    assign IntVector = vec_q;
    assign IntId     = id_q;
    assign Pending   = pending_q;
    assign Mask      = mask_q;
    assign InService = in_service_q;

endmodule

// File: tb/tb_chimpo_interrupt_controller.sv
// Directed bench for chimpo_interrupt_controller with a request scoreboard.
module tb_chimpo_interrupt_controller;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [3:0]  IrqIn;
    logic [3:0]  CurState;
    logic        MaskWe;
    logic [3:0]  MaskWdata;
    logic        IntRet;
    logic        Int;
    logic [15:0] IntVector;
    logic [1:0]  IntId;
    logic [3:0]  Pending;
    logic [3:0]  Mask;
    logic        InService;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] vec;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    chimpo_interrupt_controller dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .IrqIn     (IrqIn),
        .CurState  (CurState),
        .MaskWe    (MaskWe),
        .MaskWdata (MaskWdata),
        .IntRet    (IntRet),
        .Int       (Int),
        .IntVector (IntVector),
        .IntId     (IntId),
        .Pending   (Pending),
        .Mask      (Mask),
        .InService (InService)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic [1:0] id);
        exp_t e;
        e.id  = id;
        e.vec = 16'h0100 + 16'(id) * 16'h0010;
        sb.push_back(e);
    endtask

    // Compare the live request against the oldest scoreboard entry.
    task automatic check_req_now(input string tag);
        exp_t e;
        chk({tag, "_int"}, 32'(Int), 32'd1);
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_id"}, 32'(IntId), 32'(e.id));
            chk({tag, "_vec"}, 32'(IntVector), 32'(e.vec));
        end
    endtask

    task automatic expect_req(input string tag);
        int n = 0;
        while (Int !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_req_now(tag);
    endtask

    task automatic ack(input string tag);
        CurState = 4'd14;
        tick();
        CurState = 4'd0;
        chk({tag, "_ack_int"}, 32'(Int), 32'd0);
        chk({tag, "_ack_insvc"}, 32'(InService), 32'd1);
    endtask

    task automatic ret(input string tag);
        IntRet = 1'b1;
        tick();
        IntRet = 1'b0;
        chk({tag, "_ret_insvc"}, 32'(InService), 32'd0);
        chk({tag, "_ret_int"}, 32'(Int), 32'd0);
    endtask

    task automatic write_mask(input logic [3:0] m);
        MaskWe    = 1'b1;
        MaskWdata = m;
        tick();
        MaskWe    = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; IrqIn = '0; CurState = '0;
        MaskWe = 1'b0; MaskWdata = '0; IntRet = 1'b0;
        tick(2);
        chk("rst_pending", 32'(Pending), 32'h0);
        chk("rst_mask", 32'(Mask), 32'h0);
        chk("rst_int", 32'(Int), 32'h0);
        chk("rst_insvc", 32'(InService), 32'h0);
        chk("rst_id", 32'(IntId), 32'h0);
        chk("rst_vec", 32'(IntVector), 32'h0);
        Reset = 1'b0;
        tick();

        // Single line, exact latency
        write_mask(4'b1111);
        chk("t1_mask", 32'(Mask), 32'hf);
        IrqIn = 4'b0100;
        tick(2);
        chk("t1_pend_early", 32'(Pending), 32'h0);
        tick();
        chk("t1_pend", 32'(Pending), 32'h4);
        chk("t1_int_early", 32'(Int), 32'h0);
        push_req(2'd2);
        tick();
        check_req_now("t1_req");
        IrqIn = '0;
        ack("t1");
        chk("t1_pend_clr", 32'(Pending), 32'h0);
        ret("t1");
        tick(3);

        // Two lines together: lowest index first, then the other
        IrqIn = 4'b1010;
        push_req(2'd1);
        push_req(2'd3);
        expect_req("t2_first");
        ack("t2a");
        chk("t2_pend_after_ack", 32'(Pending), 32'h8);
        IrqIn = '0;
        ret("t2a");
        expect_req("t2_second");
        ack("t2b");
        ret("t2b");
        tick(3);

        // Masked pending fires after unmask
        write_mask(4'b0000);
        IrqIn = 4'b0001;
        tick(4);
        chk("t3_pend_masked", 32'(Pending), 32'h1);
        chk("t3_int_masked", 32'(Int), 32'h0);
        IrqIn = '0;
        write_mask(4'b0001);
        chk("t3_mask", 32'(Mask), 32'h1);
        chk("t3_int_one", 32'(Int), 32'h0);
        push_req(2'd0);
        tick();
        check_req_now("t3_req");
        ack("t3");
        ret("t3");
        tick(3);

        // Committed request ignores higher-priority arrival and IntRet
        write_mask(4'b1111);
        IrqIn = 4'b0100;
        push_req(2'd2);
        expect_req("t4_req2");
        IrqIn = 4'b0101;
        tick(4);
        chk("t4_id_held", 32'(IntId), 32'h2);
        chk("t4_int_held", 32'(Int), 32'h1);
        chk("t4_pend", 32'(Pending), 32'h5);
        IntRet = 1'b1;
        tick();
        IntRet = 1'b0;
        chk("t6_ret_req_int", 32'(Int), 32'h1);
        chk("t6_ret_req_insvc", 32'(InService), 32'h0);
        chk("t6_ret_req_id", 32'(IntId), 32'h2);
        ack("t4a");
        chk("t4_pend_ack", 32'(Pending), 32'h1);
        IrqIn = '0;
        push_req(2'd0);
        ret("t4a");
        expect_req("t4_req0");
        tick(3);
        // Edge on the acknowledged line in the very ack cycle: set wins
        IrqIn = 4'b0001;
        tick(2);
        ack("t4b");
        chk("t4_set_wins", 32'(Pending), 32'h1);
        IrqIn = '0;
        push_req(2'd0);
        ret("t4b");
        expect_req("t4_req0b");
        ack("t4c");
        chk("t4_pend_clean", 32'(Pending), 32'h0);
        ret("t4c");
        tick(3);

        // Async reset mid-service
        IrqIn = 4'b0001;
        push_req(2'd0);
        expect_req("t5_req");
        ack("t5");
        IrqIn = 4'b1011;
        tick(4);
        chk("t5_pend_svc", 32'(Pending), 32'ha);
        chk("t5_insvc", 32'(InService), 32'h1);
        chk("t5_int_svc", 32'(Int), 32'h0);
        #2 Reset = 1'b1;
        #1;
        chk("t5_rst_int", 32'(Int), 32'h0);
        chk("t5_rst_insvc", 32'(InService), 32'h0);
        chk("t5_rst_pend", 32'(Pending), 32'h0);
        chk("t5_rst_mask", 32'(Mask), 32'h0);
        Reset = 1'b0;
        IrqIn = '0;
        tick(3);
        chk("t5_post_int", 32'(Int), 32'h0);
        chk("t5_post_pend", 32'(Pending), 32'h0);

        // Ack code and IntRet while idle do nothing
        write_mask(4'b1111);
        CurState = 4'd14;
        tick();
        CurState = 4'd0;
        chk("t6_idle_ack_pend", 32'(Pending), 32'h0);
        chk("t6_idle_ack_insvc", 32'(InService), 32'h0);
        IntRet = 1'b1;
        tick();
        IntRet = 1'b0;
        chk("t6_idle_ret_int", 32'(Int), 32'h0);
        chk("t6_idle_ret_insvc", 32'(InService), 32'h0);
        tick(2);
        chk("t6_still_idle", 32'(Int), 32'h0);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chimpo_interrupt_controller.md
Name: chimpo_interrupt_controller

Overview:
Interrupt source for the CHINPO multicycle core. It collects peripheral interrupt lines, synchronises and edge-detects them, and holds them pending. It applies a software mask and a fixed priority, then drives the core's Int request and the handler vector that the core loads on its PcIn=2 path. The core acknowledges by entering its Interrupt state (state code 14). The controller observes that state on current_state, and the handler's return pulse closes the service window.

Parameters:
NUM_IRQ, 4, number of interrupt lines (1..8)
DATA_W, 16, datapath/address width
VEC_BASE, 16'h0100, handler address for IRQ 0
VEC_STRIDE, 16'h0010, address spacing between handlers
INT_STATE, 4'd14, core state code meaning "interrupt taken"

Ports:
CLK  in  1  clock
Reset  in  1  reset, asynchronous, active-high
IrqIn  in  NUM_IRQ  raw peripheral requests, asynchronous, rising-edge significant
CurState  in  4  core current_state
MaskWe  in  1  mask write strobe
MaskWdata  in  NUM_IRQ  new mask value (1 = enabled)
IntRet  in  1  one-cycle pulse: handler finished
Int  out  1  interrupt request to core, registered
IntVector  out  DATA_W  handler address, registered
IntId  out  clog2(NUM_IRQ) (min 1)  id being requested/serviced
Pending  out  NUM_IRQ  pending bits
Mask  out  NUM_IRQ  current mask
InService  out  1  handler active

Behaviour:
- Reset (async): sync flops, Pending, Mask, IntId, IntVector, Int and InService all go to 0; FSM goes to IDLE. Reset mid-service drops everything, including pending requests.
- Per line: two-flop synchroniser (s1, s2) plus a previous flop s3. Edge = s2 & ~s3.
- Pending[i] is set on Edge[i]. It is cleared only at acknowledge, and only for the latched IntId. If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Latency: IrqIn first sampled high at edge k → Pending set after edge k+2 → Int=1 after edge k+3 (IDLE, unmasked). Pulses shorter than 1 clock are not guaranteed to be caught.
- Mask: MaskWe loads MaskWdata at the next edge, in any state. Pending bits are recorded even while masked and fire when the line is unmasked.
- Candidate = Pending & Mask. Priority is fixed: the lowest index wins.
- FSM, three states:
  - IDLE: Int=0, InService=0. If Candidate != 0, latch IntId = winner and IntVector = VEC_BASE + IntId*VEC_STRIDE (truncated to DATA_W), set Int=1, go to REQ.
  - REQ: Int held at 1; IntId and IntVector stay stable. The request is committed: masking or a higher-priority arrival does not retract or re-arbitrate it. When CurState==INT_STATE, at that edge: clear Pending[IntId], set Int=0 and InService=1, go to SERVICE. IntRet is ignored in REQ.
  - SERVICE: Int=0 and there is no nesting, though new edges still set Pending. On IntRet, set InService=0 and go to IDLE. Re-arbitration happens in IDLE on the following cycle, giving at least one cycle with Int=0 between requests. IntVector and IntId hold their last values.
- IntRet in IDLE has no effect.
- Int is deasserted one cycle after the core's Interrupt state. The core's next sample point is at least 3 cycles later (Fetch, Decode, execute), so one ack can never be taken twice.
- CurState values other than INT_STATE have no effect.

Decomposition:
- Shared package chimpo_pkg holds:
  - core state codes (FETCH=0 … INTERRUPT=14, RESET_STATE=13)
  - DATA_W
  - the FSM enum for IDLE, REQ and SERVICE
- Natural sub-module: chimpo_irq_sync. It contains the 2-flop synchroniser, the s3 flop and the rising-edge pulse for one line, and is instantiated NUM_IRQ times with a generate loop.
- Priority encoder, vector arithmetic and FSM stay in the top module.

Test Plan:
1. Reset, Mask=4'b1111, IrqIn[2] rises at edge 10 → Pending=4'b0100 after edge 12, Int=1, IntId=2, IntVector=16'h0120 after edge 13. CurState=14 for one cycle → next cycle Int=0, InService=1, Pending=0. IntRet pulse → InService=0.
2. IrqIn[3] and IrqIn[1] rise in the same cycle → IntId=1, vector 16'h0110 first. After ack and IntRet, Int=1 again with IntId=3, vector 16'h0130, at least 1 cycle after IntRet.
3. Mask=4'b0000, IrqIn[0] edge → Pending=4'b0001, Int stays 0. Write Mask=4'b0001 → Int=1 two edges after MaskWe.
4. In REQ for IntId=2, IrqIn[0] edge arrives → IntId stays 2 until ack; IRQ 0 is served after IntRet. Separately, IrqIn[2] edge in the exact ack cycle → Pending[2] remains 1.
5. Assert Reset asynchronously mid-SERVICE with Pending=4'b1010 → Int, InService, Pending and Mask are 0 immediately, with no clock required; after release the FSM is in IDLE and Int stays 0.
6. IntRet pulses in IDLE and in REQ → no state change. CurState=14 while in IDLE → no Pending change.
